// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial word transmitter with valid/ready input and idle gap
// Optional: define SEQ_PATTERN_TX_REPEAT_EN to retransmit the last accepted word indefinitely.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x,
  output logic             active,
  output logic             last
);

  localparam int MAXV = (WIDTH - 1 > GAP - 1) ? WIDTH - 1 : GAP - 1;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_x;
  logic             r_active;
  logic             r_last;
  logic             w_accept;

  // With no gap, the final bit cycle doubles as the acceptance slot so words stream seamlessly.
  assign ready_out = (r_state == ST_IDLE) ||
                     ((GAP == 0) && (r_state == ST_SHIFT) && (r_cnt == '0));
  assign w_accept  = valid_in && ready_out;

  assign x      = r_x;
  assign active = r_active;
  assign last   = r_last;

`ifdef SEQ_PATTERN_TX_REPEAT_EN
  logic [WIDTH-1:0] r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
    end else if (w_accept) begin
      r_word <= data_in;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_sh_nxt    = data_in;
          w_cnt_nxt   = CW'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (r_cnt != '0) begin
          w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (GAP > 0) begin
          w_state_nxt = ST_GAP;
          w_sh_nxt    = '0;
          w_cnt_nxt   = CW'(GAP - 1);
        end else if (w_accept) begin
          w_sh_nxt  = data_in;
          w_cnt_nxt = CW'(WIDTH - 1);
        end else begin
`ifdef SEQ_PATTERN_TX_REPEAT_EN
          w_sh_nxt  = r_word;
          w_cnt_nxt = CW'(WIDTH - 1);
`else
          w_state_nxt = ST_IDLE;
          w_sh_nxt    = '0;
`endif
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
`ifdef SEQ_PATTERN_TX_REPEAT_EN
          w_state_nxt = ST_SHIFT;
          w_sh_nxt    = r_word;
          w_cnt_nxt   = CW'(WIDTH - 1);
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_x      <= 1'b0;
      r_active <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sh     <= w_sh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_x      <= (w_state_nxt == ST_SHIFT) && w_sh_nxt[WIDTH-1];
      r_active <= (w_state_nxt == ST_SHIFT);
      r_last   <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx (GAP=1 and GAP=0 instances)
module tb_seq_pattern_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vin  [2];
  logic [W-1:0] din  [2];
  logic         rdy  [2];
  logic         xo   [2];
  logic         act  [2];
  logic         lst  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a word occupies a frame of W bit slots followed by gap_of(i) idle slots.
  int           m_busy [2];
  int           m_pos  [2];
  logic [W-1:0] m_word [2];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .GAP(1)) u_g1 (
    .clk(clk), .reset(rst_n), .data_in(din[0]), .valid_in(vin[0]),
    .ready_out(rdy[0]), .x(xo[0]), .active(act[0]), .last(lst[0])
  );

  seq_pattern_tx #(.WIDTH(W), .GAP(0)) u_g0 (
    .clk(clk), .reset(rst_n), .data_in(din[1]), .valid_in(vin[1]),
    .ready_out(rdy[1]), .x(xo[1]), .active(act[1]), .last(lst[1])
  );

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic m_ready(int i);
    return (m_busy[i] == 0) || (gap_of(i) == 0 && m_pos[i] == W - 1);
  endfunction

  function automatic logic [3:0] m_outs(int i);
    logic bit_slot;
    bit_slot = (m_busy[i] != 0) && (m_pos[i] < W);
    return {bit_slot ? m_word[i][W-1-m_pos[i]] : 1'b0,
            bit_slot,
            bit_slot && (m_pos[i] == W - 1),
            m_ready(i)};
  endfunction

  function automatic logic [3:0] d_outs(int i);
    return {xo[i], act[i], lst[i], rdy[i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_pos[i]  = 0;
      m_word[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (vin[i] && m_ready(i)) begin
        m_word[i] = din[i];
        m_pos[i]  = 0;
        m_busy[i] = 1;
      end else if (m_busy[i] != 0 && m_pos[i] < W + gap_of(i) - 1) begin
        m_pos[i]++;
      end else if (m_busy[i] != 0) begin
`ifdef SEQ_PATTERN_TX_REPEAT_EN
        m_pos[i] = 0;
`else
        m_busy[i] = 0;
`endif
      end
    end
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (d_outs(i) !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_hold inst%0d got %b exp %b", i, d_outs(i), 4'b0001);
      end
    end
    rst_n = 1'b1;
    model_clear();
    repeat (2) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (d_outs(i) !== m_outs(i)) begin
          n_fail++;
          $display("FAIL reset_release inst%0d got %b exp %b", i, d_outs(i), m_outs(i));
        end
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] xs, ls, rd;
    do_reset();
    vin[0] = 1'b1;
    din[0] = 4'b1011;
    step();
    vin[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xs[k] = xo[0];
      ls[k] = lst[0];
      rd[k] = rdy[0];
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (d_outs(i) !== m_outs(i)) begin
          n_fail++;
          $display("FAIL single inst%0d k%0d got %b exp %b", i, k, d_outs(i), m_outs(i));
        end
      end
      step();
    end
    n_tests++;
    if (xs[4:0] !== 5'b01101) begin
      n_fail++;
      $display("FAIL single_bits got %b exp %b", xs[4:0], 5'b01101);
    end
    n_tests++;
    if (ls[4:0] !== 5'b01000) begin
      n_fail++;
      $display("FAIL single_last got %b exp %b", ls[4:0], 5'b01000);
    end
    n_tests++;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
    if (rd[5:0] !== 6'b000000) begin
      n_fail++;
      $display("FAIL single_ready got %b exp %b", rd[5:0], 6'b000000);
    end
`else
    if (rd[5:0] !== 6'b100000) begin
      n_fail++;
      $display("FAIL single_ready got %b exp %b", rd[5:0], 6'b100000);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic       acc2;
    int         det;
    do_reset();
    vin[1] = 1'b1;
    din[1] = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      acc2 = vin[1] && m_ready(1) && (din[1] == 4'b0110);
      step();
      if (c == 0) din[1] = 4'b0110;
      if (acc2) vin[1] = 1'b0;
      s[c] = xo[1];
      n_tests++;
      if (d_outs(1) !== m_outs(1)) begin
        n_fail++;
        $display("FAIL b2b c%0d got %b exp %b", c, d_outs(1), m_outs(1));
      end
    end
    n_tests++;
    if (s !== 8'b01101101) begin
      n_fail++;
      $display("FAIL b2b_stream got %b exp %b", s, 8'b01101101);
    end
    det = 0;
    for (int c = 3; c < 8; c++) begin
      if ({s[c-3], s[c-2], s[c-1], s[c]} == 4'b1011) det++;
    end
    n_tests++;
    if (det !== 2) begin
      n_fail++;
      $display("FAIL b2b_detections got %0d exp %0d", det, 2);
    end
  endtask

  task automatic test_busy_ignore();
    int run, max_run;
    do_reset();
    vin[0] = 1'b1;
    din[0] = 4'b1011;
    step();
    vin[0] = 1'b0;
    step();
    vin[0] = 1'b1;
    din[0] = 4'b1111;
    step();
    vin[0] = 1'b0;
    run     = 0;
    max_run = 0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (d_outs(0) !== m_outs(0)) begin
        n_fail++;
        $display("FAIL busy k%0d got %b exp %b", k, d_outs(0), m_outs(0));
      end
      run     = xo[0] ? run + 1 : 0;
      max_run = (run > max_run) ? run : max_run;
      step();
    end
    n_tests++;
    if (max_run > 2) begin
      n_fail++;
      $display("FAIL busy_run got %0d exp <= %0d", max_run, 2);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] xs;
    do_reset();
    vin[0] = 1'b1;
    din[0] = 4'b1011;
    step();
    vin[0] = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (d_outs(i) !== 4'b0001) begin
        n_fail++;
        $display("FAIL midreset_async inst%0d got %b exp %b", i, d_outs(i), 4'b0001);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
    vin[0] = 1'b1;
    din[0] = 4'b0110;
    step();
    vin[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) xs[3-k] = xo[0];
      n_tests++;
      if (d_outs(0) !== m_outs(0)) begin
        n_fail++;
        $display("FAIL midreset_fresh k%0d got %b exp %b", k, d_outs(0), m_outs(0));
      end
      step();
    end
    n_tests++;
    if (xs !== 4'b0110) begin
      n_fail++;
      $display("FAIL midreset_word got %b exp %b", xs, 4'b0110);
    end
  endtask

  task automatic test_repeat();
    logic [4:0] pat;
    logic       e;
    pat = 5'b10110;
    do_reset();
    vin[0] = 1'b1;
    din[0] = 4'b1011;
    step();
    vin[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
`ifdef SEQ_PATTERN_TX_REPEAT_EN
      e = pat[4 - (k % 5)];
`else
      e = (k < 5) ? pat[4 - k] : 1'b0;
`endif
      n_tests++;
      if (xo[0] !== e) begin
        n_fail++;
        $display("FAIL repeat_x k%0d got %b exp %b", k, xo[0], e);
      end
      n_tests++;
      if (d_outs(0) !== m_outs(0)) begin
        n_fail++;
        $display("FAIL repeat_model k%0d got %b exp %b", k, d_outs(0), m_outs(0));
      end
      step();
    end
  endtask

  task automatic test_random();
    logic hold [2];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) hold[i] = vin[i] && !m_ready(i);
      step();
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (d_outs(i) !== m_outs(i)) begin
          n_fail++;
          $display("FAIL random inst%0d c%0d got %b exp %b", i, c, d_outs(i), m_outs(i));
        end
        if (!hold[i]) begin
          vin[i] = 1'($urandom_range(0, 1));
          din[i] = W'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0;
      din[i] = '0;
    end
    model_clear();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
